// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP learner: rule encodings, saturating
// arithmetic and the flattened weight-matrix index helper.
package stdp_pkg;

  localparam logic MODE_HEBB = 1'b0;
  localparam logic MODE_STDP = 1'b1;

  // int is wider than the W+2 bits needed for w + dw for any W up to 30,
  // so the sum can never wrap before it is clamped.
  function automatic int sat_add(input int w, input int dw,
                                 input int w_min, input int w_max);
    int sum;
    sum = w + dw;
    if (sum > w_max) return w_max;
    if (sum < w_min) return w_min;
    return sum;
  endfunction

  function automatic int flat_idx(input int i, input int j,
                                  input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// Per-neuron eligibility trace: loads TRACE_MAX on a spike, then counts
// down by one per cycle until it reaches zero.
module stdp_trace #(
  parameter int T         = 4,
  parameter int TRACE_MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         spike,
  output logic [T-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (spike)
      count <= T'(TRACE_MAX);
    else if (count != '0)
      count <= count - T'(1);
  end

endmodule

// File: rtl/stdp_learning.sv
// N x N signed weight matrix trained every cycle from the spike vector,
// using either Hebbian coincidence or pair-based STDP with saturation.
module stdp_learning
  import stdp_pkg::*;
#(
  parameter int N         = 7,
  parameter int W         = 16,
  parameter int T         = 4,
  parameter int TRACE_MAX = 15,
  parameter int ETA_P     = 1,
  parameter int LTP_SHIFT = 0,
  parameter int LTD_SHIFT = 0,
  parameter int W_MAX     = 2 ** (W - 1) - 1,
  parameter int W_MIN     = -(2 ** (W - 1)) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             learning_enable,
  input  logic             mode,
  input  logic             weight_clear,
  input  logic [N-1:0]     spikes,
  output logic [N*N*W-1:0] weights_flat,
  output logic             update_pulse
);

  logic [N-1:0][T-1:0] trace_q;
  logic signed [W-1:0] w_q [N][N];
  logic signed [W-1:0] w_d [N][N];
  logic                changed;

  for (genvar k = 0; k < N; k++) begin : g_trace
    stdp_trace #(
      .T        (T),
      .TRACE_MAX(TRACE_MAX)
    ) u_trace (
      .clk  (clk),
      .reset(reset),
      .clear(weight_clear),
      .spike(spikes[k]),
      .count(trace_q[k])
    );
  end

  // Weight updates see the traces as they were before this edge, so a
  // neuron's own spike this cycle never feeds its own trace into dw.
  always_comb begin
    int dw;
    int ltp;
    int ltd;
    int sum;
    changed = 1'b0;
    dw      = 0;
    ltp     = 0;
    ltd     = 0;
    sum     = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_d[i][j] = w_q[i][j];
        if (learning_enable && (i != j)) begin
          if (mode == MODE_HEBB) begin
            dw = (spikes[i] && spikes[j]) ? ETA_P : 0;
          end else begin
            ltp = spikes[j] ? (int'(trace_q[i]) >>> LTP_SHIFT) : 0;
            ltd = spikes[i] ? (int'(trace_q[j]) >>> LTD_SHIFT) : 0;
            dw  = ltp - ltd;
          end
          sum       = sat_add(int'(w_q[i][j]), dw, W_MIN, W_MAX);
          w_d[i][j] = W'(sum);
          if (w_d[i][j] != w_q[i][j])
            changed = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w_q[i][j] <= '0;
      update_pulse <= 1'b0;
    end else if (weight_clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w_q[i][j] <= '0;
      update_pulse <= 1'b0;
    end else begin
      w_q          <= w_d;
      update_pulse <= changed;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign weights_flat[flat_idx(i, j, N, W) +: W] = w_q[i][j];
    end
  end

endmodule

// File: tb/tb_stdp_learning.sv
// Self-checking bench for stdp_learning: directed table, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_stdp_learning;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int T    = 4;
  localparam int TM   = 8;
  localparam int WMAX = 127;
  localparam int WMIN = -127;

  logic             clk = 1'b0;
  logic             reset;
  logic             learning_enable;
  logic             mode;
  logic             weight_clear;
  logic [N-1:0]     spikes;
  logic [N*N*W-1:0] weights_flat;
  logic             update_pulse;

  int errors = 0;
  int checks = 0;

  int mw [N][N];
  int mt [N];
  bit mp;

  typedef struct {
    logic [N-1:0] spk;
    logic         le;
    logic         m;
    logic         clr;
    logic [W-1:0] w01;
    logic [W-1:0] w10;
    logic         pulse;
  } vec_t;

  vec_t tbl [11];

  stdp_learning #(
    .N(N), .W(W), .T(T), .TRACE_MAX(TM), .ETA_P(1),
    .LTP_SHIFT(1), .LTD_SHIFT(1), .W_MAX(WMAX), .W_MIN(WMIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .learning_enable(learning_enable),
    .mode           (mode),
    .weight_clear   (weight_clear),
    .spikes         (spikes),
    .weights_flat   (weights_flat),
    .update_pulse   (update_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*N*W-1:0] model_flat();
    logic [N*N*W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        f[(i*N+j)*W +: W] = W'(mw[i][j]);
    return f;
  endfunction

  function automatic logic [N*T-1:0] model_traces();
    logic [N*T-1:0] t;
    for (int k = 0; k < N; k++)
      t[k*T +: T] = T'(mt[k]);
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mt[i] = 0;
      for (int j = 0; j < N; j++) mw[i][j] = 0;
    end
    mp = 1'b0;
  endtask

  // Reference behaviour: dw from the selected rule using pre-edge traces,
  // clamp to the bounds, then advance traces.
  task automatic model_step(input logic [N-1:0] s, input logic le, input logic m, input logic clr);
    int old [N];
    int dw, nv;
    bit ch;
    if (clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) old[k] = mt[k];
    ch = 1'b0;
    if (le) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i == j) continue;
          if (m) dw = (s[j] ? old[i] / 2 : 0) - (s[i] ? old[j] / 2 : 0);
          else   dw = (s[i] && s[j]) ? 1 : 0;
          nv = mw[i][j] + dw;
          if (nv > WMAX) nv = WMAX;
          if (nv < WMIN) nv = WMIN;
          if (nv != mw[i][j]) ch = 1'b1;
          mw[i][j] = nv;
        end
      end
    end
    for (int k = 0; k < N; k++)
      mt[k] = s[k] ? TM : (old[k] > 0 ? old[k] - 1 : 0);
    mp = ch;
  endtask

  task automatic applyStimulus(input logic [N-1:0] s, input logic le, input logic m, input logic clr);
    spikes          = s;
    learning_enable = le;
    mode            = m;
    weight_clear    = clr;
    @(posedge clk);
    model_step(s, le, m, clr);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " weights"}, 128'(weights_flat), 128'(model_flat()));
    check({tag, " pulse"}, 128'(update_pulse), 128'(mp));
    check({tag, " traces"}, 128'(dut.trace_q), 128'(model_traces()));
  endtask

  initial begin
    reset           = 1'b1;
    spikes          = '0;
    learning_enable = 1'b0;
    mode            = 1'b0;
    weight_clear    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("reset");
    check("reset weights zero", 128'(weights_flat), 128'(0));
    reset = 1'b0;

    for (int k = 0; k < 5; k++)
      tbl[k] = '{4'b0011, 1'b1, 1'b0, 1'b0, W'(k + 1), W'(k + 1), 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0};
    tbl[6]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
    tbl[9]  = '{4'b0010, 1'b1, 1'b1, 1'b0, 8'h03, 8'hFD, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 8'h03, 8'hFD, 1'b0};

    for (int r = 0; r < 11; r++) begin
      applyStimulus(tbl[r].spk, tbl[r].le, tbl[r].m, tbl[r].clr);
      check($sformatf("table%0d w01", r), 128'(weights_flat[15:8]), 128'(tbl[r].w01));
      check($sformatf("table%0d w10", r), 128'(weights_flat[39:32]), 128'(tbl[r].w10));
      check($sformatf("table%0d pulse", r), 128'(update_pulse), 128'(tbl[r].pulse));
      checkOutput($sformatf("table%0d", r));
    end

    // Positive saturation under Hebbian coincidence
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 130; c++) begin
      applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_hebb");
      if (c == 127) check("sat pulse at 127", 128'(update_pulse), 128'(1));
      if (c == 128) check("sat pulse after clamp", 128'(update_pulse), 128'(0));
    end
    check("sat w01 max", 128'(weights_flat[15:8]), 128'(8'h7F));

    // Repeated causal pairs drive w01 to the upper bound and w10 to the lower
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 45; p++) begin
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0);
      checkOutput("stdp_sat");
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
      checkOutput("stdp_sat");
      for (int z = 0; z < 8; z++) applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    end
    check("stdp w01 max", 128'(weights_flat[15:8]), 128'(8'h7F));
    check("stdp w10 min", 128'(weights_flat[39:32]), 128'(8'h81));

    // Learning disabled: weights frozen, traces still run
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(N'($urandom), 1'b0, 1'($urandom), 1'b0);
      checkOutput("le_off");
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput("le_off_decay");
    end
    check("le_off traces zero", 128'(dut.trace_q), 128'(0));
    check("le_off weights zero", 128'(weights_flat), 128'(0));

    // Clear beats simultaneous spikes
    for (int c = 0; c < 3; c++) applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1);
    checkOutput("clear");
    check("clear weights", 128'(weights_flat), 128'(0));
    check("clear traces", 128'(dut.trace_q), 128'(0));
    check("clear pulse", 128'(update_pulse), 128'(0));

    // Asynchronous reset between edges
    for (int c = 0; c < 3; c++) applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #2;
    model_reset();
    checkOutput("async_reset");
    check("async weights", 128'(weights_flat), 128'(0));
    check("async pulse", 128'(update_pulse), 128'(0));
    #2;
    reset = 1'b0;
    applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset");
    check("post_reset w01", 128'(weights_flat[15:8]), 128'(8'h01));

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      applyStimulus(N'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                    1'($urandom_range(0, 31) == 0));
      checkOutput($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
